reorder_buffer: RTL
===================

# reorder_buffer

Sixteen-entry circular reorder buffer that issues the 4-bit instruction index carried by every dispatched instruction into the reservation stations. It captures results broadcast on the 4-port common data bus and answers operand-readiness lookups at dispatch. It retires completed instructions strictly in program order to the architectural register file, at most one per cycle.

## Interface
- DATA_W, 16, result/value width (matches CDB result width)
- DEPTH is fixed at 16 (index width 4); not a parameter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_dest  in  4  architectural destination register of dispatched instruction
- alloc_ready  out  1  combinational; 1 when count < 16
- alloc_index  out  4  combinational; current tail, the index handed to the reservation station
- cdb_valid[0:3]  in  1 each  CDB port valid
- cdb_rob_index[0:3]  in  4 each  CDB producer index
- cdb_result[0:3]  in  DATA_W each  CDB result
- q_index1, q_index2  in  4  operand lookup indices
- q_ready1, q_ready2  out  1  combinational; entry done (stored or same-cycle CDB hit)
- q_value1, q_value2  out  DATA_W  combinational; value when ready, else 0
- commit_valid  out  1  registered; one instruction retired
- commit_index  out  4  registered; retired entry index
- commit_dest  out  4  registered; architectural register to write
- commit_value  out  DATA_W  registered; value to write
- flush  in  1  discard all entries (mispredict/exception)
- count  out  5  registered occupancy 0..16

## Operation
- Per entry: valid, done, dest[3:0], value[DATA_W-1:0]. Pointers head, tail (4 bits, wrap 15→0), count (5 bits).
- Allocate: when alloc_valid & alloc_ready at the edge, entry[tail] <= {valid=1, done=0, dest=alloc_dest, value=0}; tail++. alloc_valid with alloc_ready=0 is ignored.
- alloc_ready uses the current count only; a commit in the same cycle does not free a slot for the same-cycle allocation.
- CDB capture: for each entry that is valid and not done, the lowest-numbered port p with cdb_valid[p] and a matching index sets done=1 and value=cdb_result[p].
- CDB writes to invalid or already-done entries are ignored. This includes the tail entry being allocated in the same cycle.
- Lookup: q_readyN = entry[q_indexN].valid & (done | a CDB port matching this cycle). q_valueN takes the stored value, else the lowest matching port's result.
- Commit: at the edge, if entry[head].valid & done (stored state, not a same-cycle CDB hit), the commit registers are loaded from the head entry, commit_valid <= 1, entry[head].valid <= 0, and head++. Otherwise commit_valid <= 0.
- count next = count + alloc_fire − commit_fire.
- Flush: priority over alloc, CDB and commit in the same cycle. All valid/done <= 0, head = tail = count = 0, commit_valid <= 0.
- Reset: same as flush. In addition commit_index, commit_dest and commit_value <= 0. Entry dest/value are don't-care.

## Timing
- Reset values: commit_valid 0, commit_index 0, commit_dest 0, commit_value 0, count 0. alloc_ready is 1 and alloc_index is 0 after reset.
- Allocation at edge A: the earliest accepted CDB write for that entry is at edge A+1, and the earliest commit is at edge A+2. commit_valid is high in the cycle after edge A+2.
- A CDB hit is visible on q_ready/q_value combinationally in the same cycle and from stored state thereafter. This prevents lost wakeups at dispatch.
- Maximum throughput: 1 allocation and 1 commit per cycle, sustained, including while full (commit) or empty (alloc).
- Full (count 16): alloc_ready 0 and tail == head. Empty (count 0): no commit.
- Reset or flush asserted mid-stream takes effect at that edge. No commit issues on that edge.

## Test plan
- Reset then 16 allocations, dest=i -> alloc_index 0..15, count 16, alloc_ready 0. A 17th alloc_valid is ignored and count stays 16.
- Allocate 0,1,2; CDB writes idx2=0x0033, then idx0=0x0011, then idx1=0x0022 -> commits in order 0,1,2 with values 0x0011, 0x0022, 0x0033 on consecutive cycles once idx1 is done.
- Same cycle, cdb_valid[1] idx5=0xAAAA and cdb_valid[3] idx5=0xBBBB -> entry 5 value 0xAAAA. Lookup q_index1=5 reads ready/0xAAAA in that same cycle.
- Run 20 alloc/commit pairs -> tail and head wrap 15→0. commit_index sequence is 0..15,0..3 and count never exceeds its expected value.
- Full buffer, head done, assert alloc_valid and commit in the same cycle -> commit fires, alloc rejected, count 15. The next cycle alloc accepted at index 0.
- 5 entries live, 3 done; assert flush together with a CDB write and alloc_valid -> count 0, commit_valid 0, next alloc_index 0, and no stale commit afterwards.

Source files
------------

// File: rtl/reorder_buffer.sv
// Sixteen-entry circular reorder buffer: allocates indices at dispatch, captures
// results from a 4-port CDB, forwards operand readiness, retires one entry per cycle in order.
module reorder_buffer #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_dest,
    output logic              alloc_ready,
    output logic [3:0]        alloc_index,
    input  logic              cdb_valid     [0:3],
    input  logic [3:0]        cdb_rob_index [0:3],
    input  logic [DATA_W-1:0] cdb_result    [0:3],
    input  logic [3:0]        q_index1,
    input  logic [3:0]        q_index2,
    output logic              q_ready1,
    output logic              q_ready2,
    output logic [DATA_W-1:0] q_value1,
    output logic [DATA_W-1:0] q_value2,
    output logic              commit_valid,
    output logic [3:0]        commit_index,
    output logic [3:0]        commit_dest,
    output logic [DATA_W-1:0] commit_value,
    input  logic              flush,
    output logic [4:0]        count
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned PORTS = 4;

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [IDX_W-1:0]  dest  [DEPTH];
    logic [DATA_W-1:0] value [DEPTH];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;

    logic [DEPTH-1:0]  hit;
    logic [DATA_W-1:0] hit_value [DEPTH];
    logic              alloc_fire;
    logic              commit_fire;

    // Per-entry CDB match; descending scan leaves the lowest matching port in place.
    always_comb begin : cdb_match
        hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
            hit_value[e] = '0;
            for (int p = PORTS - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_rob_index[p] == IDX_W'(e))) begin
                    hit[e]       = 1'b1;
                    hit_value[e] = cdb_result[p];
                end
            end
        end
    end

    always_comb begin : control
        alloc_ready = (count < CNT_W'(DEPTH));
        alloc_index = tail;
        alloc_fire  = alloc_valid & alloc_ready;
        // Retirement looks only at stored state, never at a same-cycle CDB hit.
        commit_fire = valid[head] & done[head];
    end

    // Operand lookup with same-cycle CDB forwarding so dispatch never misses a wakeup.
    always_comb begin : lookup
        q_ready1 = valid[q_index1] & (done[q_index1] | hit[q_index1]);
        q_ready2 = valid[q_index2] & (done[q_index2] | hit[q_index2]);
        q_value1 = '0;
        q_value2 = '0;
        if (q_ready1) q_value1 = done[q_index1] ? value[q_index1] : hit_value[q_index1];
        if (q_ready2) q_value2 = done[q_index2] ? value[q_index2] : hit_value[q_index2];
    end

    always_ff @(posedge clk) begin : state_regs
        if (rst || flush) begin
            valid        <= '0;
            done         <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            if (rst) begin
                commit_index <= '0;
                commit_dest  <= '0;
                commit_value <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid[e] && !done[e] && hit[e]) done[e] <= 1'b1;
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + IDX_W'(1);
            end
            commit_valid <= commit_fire;
            if (commit_fire) begin
                valid[head]  <= 1'b0;
                head         <= head + IDX_W'(1);
                commit_index <= head;
                commit_dest  <= dest[head];
                commit_value <= value[head];
            end
            count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    // Payload storage needs no reset: it is only read behind valid/done.
    always_ff @(posedge clk) begin : entry_data
        for (int e = 0; e < DEPTH; e++) begin
            if (!rst && !flush && valid[e] && !done[e] && hit[e]) value[e] <= hit_value[e];
        end
        if (!rst && !flush && alloc_fire) begin
            dest[tail]  <= alloc_dest;
            value[tail] <= '0;
        end
    end

endmodule
